// File: rtl/vme_requester_pkg.sv
// ============================================================================
// Module      : vme_req_pkg
// Description : Shared types and constants for the VME bus requester.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package vme_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_OWN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int SYNC_STAGES = 2;
  localparam int HOLD_W      = 3;
`ifdef VME_REQUESTER_TIMEOUT_EN
  localparam int TO_W        = 8;
`endif

endpackage

`default_nettype wire

// File: rtl/vme_requester_if.sv
// ============================================================================
// Module      : vme_requester_if
// Description : Local-master handshake plus VME arbitration lines of one slot.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface vme_requester_if;
  logic req;
  logic done;
  logic grant;
  logic rel_req;
  logic req_err;
  logic vme_bgin_n;
  logic vme_bclr_n;
  logic vme_bbsy_in_n;
  logic vme_br_n;
  logic vme_bgout_n;
  logic vme_bbsy_n;

  // Requester side
  modport slave (
    input  req, done, vme_bgin_n, vme_bclr_n, vme_bbsy_in_n,
    output grant, rel_req, req_err, vme_br_n, vme_bgout_n, vme_bbsy_n
  );

  // Local master / bus environment side
  modport master (
    output req, done, vme_bgin_n, vme_bclr_n, vme_bbsy_in_n,
    input  grant, rel_req, req_err, vme_br_n, vme_bgout_n, vme_bbsy_n
  );
endinterface

`default_nettype wire

// File: rtl/vme_sync2.sv
// ============================================================================
// Module      : vme_sync2
// Description : Two-flop synchronizer for an asynchronous active-low line,
//               resets to the inactive (1) level.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vme_sync2
  import vme_req_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/vme_requester.sv
// ============================================================================
// Module      : vme_requester
// Description : Per-slot VME bus requester (BR/BBSY/BG daisy chain).
//               Optional grant timeout: VME_REQUESTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vme_requester
  import vme_req_pkg::*;
#(
  parameter int BBSY_MIN_CYC = 4
`ifdef VME_REQUESTER_TIMEOUT_EN
  , parameter int GRANT_TO_CYC = 255
`endif
) (
  input logic            clk,
  input logic            reset,
  vme_requester_if.slave bus
);

  logic w_bgin_s;
  logic w_bclr_s;
  logic w_bbsy_s;
  logic w_req_ok;

  state_e            r_state;
  logic              r_br_n;
  logic              r_bgout_n;
  logic              r_bbsy_n;
  logic              r_grant;
  logic              r_rel_req;
  logic              r_done_pend;
  logic [HOLD_W-1:0] r_hold;

  vme_sync2 u_sync_bgin (.clk(clk), .reset(reset), .i_d(bus.vme_bgin_n),    .o_q(w_bgin_s));
  vme_sync2 u_sync_bclr (.clk(clk), .reset(reset), .i_d(bus.vme_bclr_n),    .o_q(w_bclr_s));
  vme_sync2 u_sync_bbsy (.clk(clk), .reset(reset), .i_d(bus.vme_bbsy_in_n), .o_q(w_bbsy_s));

`ifdef VME_REQUESTER_TIMEOUT_EN
  logic            r_req_err;
  logic            r_req_block;
  logic [TO_W-1:0] r_to_cnt;

  // After a timeout, req must be dropped before another request is made
  assign w_req_ok    = ~r_req_block;
  assign bus.req_err = r_req_err;
`else
  assign w_req_ok    = 1'b1;
  assign bus.req_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_br_n      <= 1'b1;
      r_bgout_n   <= 1'b1;
      r_bbsy_n    <= 1'b1;
      r_grant     <= 1'b0;
      r_rel_req   <= 1'b0;
      r_done_pend <= 1'b0;
      r_hold      <= '0;
`ifdef VME_REQUESTER_TIMEOUT_EN
      r_req_err   <= 1'b0;
      r_req_block <= 1'b0;
      r_to_cnt    <= '0;
`endif
    end else begin
`ifdef VME_REQUESTER_TIMEOUT_EN
      r_req_err <= 1'b0;
      if (!bus.req) r_req_block <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_bgout_n <= w_bgin_s;
          // r_bgout_n low means a grant is still being forwarded: never steal it
          if (bus.req && w_req_ok && w_bgin_s && r_bgout_n) begin
            r_br_n  <= 1'b0;
            r_state <= ST_REQ;
`ifdef VME_REQUESTER_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end

        ST_REQ: begin
          r_bgout_n <= 1'b1;
          if (!bus.req) begin
            r_br_n  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (!w_bgin_s && w_bbsy_s) begin
            r_bbsy_n    <= 1'b0;
            r_br_n      <= 1'b1;
            r_hold      <= HOLD_W'(BBSY_MIN_CYC);
            r_done_pend <= 1'b0;
            r_state     <= ST_OWN;
          end
`ifdef VME_REQUESTER_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(GRANT_TO_CYC - 1)) begin
            r_br_n      <= 1'b1;
            r_req_err   <= 1'b1;
            r_req_block <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end

        ST_OWN: begin
          r_bgout_n <= 1'b1;
          if (r_hold != '0) r_hold <= r_hold - 1'b1;
          // Release on the edge where the hold count reaches (or already is) zero
          if ((bus.done || r_done_pend) && (r_hold <= HOLD_W'(1))) begin
            r_bbsy_n    <= 1'b1;
            r_grant     <= 1'b0;
            r_rel_req   <= 1'b0;
            r_done_pend <= 1'b0;
            r_state     <= ST_RELEASE;
          end else begin
            r_grant     <= 1'b1;
            r_done_pend <= r_done_pend | bus.done;
            r_rel_req   <= ~w_bclr_s & ~bus.done & ~r_done_pend;
          end
        end

        ST_RELEASE: begin
          r_bgout_n <= 1'b1;
          if (w_bgin_s) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vme_br_n    = r_br_n;
  assign bus.vme_bgout_n = r_bgout_n;
  assign bus.vme_bbsy_n  = r_bbsy_n;
  assign bus.grant       = r_grant;
  assign bus.rel_req     = r_rel_req;

endmodule

`default_nettype wire

// File: tb/tb_vme_requester.sv
// ============================================================================
// Module      : tb_vme_requester
// Description : Directed self-checking bench for vme_requester.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vme_requester;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  vme_requester_if bus_if ();

`ifdef VME_REQUESTER_TIMEOUT_EN
  vme_requester #(.BBSY_MIN_CYC(4), .GRANT_TO_CYC(10)) dut (
`else
  vme_requester #(.BBSY_MIN_CYC(4)) dut (
`endif
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Request and win the bus; returns just after grant rises
  task automatic acquire();
    bus_if.req = 1'b1;
    tick(1);
    bus_if.vme_bgin_n = 1'b0;
    tick(3);
    bus_if.req = 1'b0;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus_if.req           = 1'b0;
    bus_if.done          = 1'b0;
    bus_if.vme_bgin_n    = 1'b1;
    bus_if.vme_bclr_n    = 1'b1;
    bus_if.vme_bbsy_in_n = 1'b1;
    tick(3);

    check("rst_br_n",    bus_if.vme_br_n,    8'd1);
    check("rst_bgout_n", bus_if.vme_bgout_n, 8'd1);
    check("rst_bbsy_n",  bus_if.vme_bbsy_n,  8'd1);
    check("rst_grant",   bus_if.grant,       8'd0);
    check("rst_rel_req", bus_if.rel_req,     8'd0);
    check("rst_req_err", bus_if.req_err,     8'd0);
    reset = 1'b0;
    tick(2);

    // Idle pass-through: 3-cycle latency each way
    bus_if.vme_bgin_n = 1'b0;
    tick(2);
    check("pass_lat2",    bus_if.vme_bgout_n, 8'd1);
    tick(1);
    check("pass_low",     bus_if.vme_bgout_n, 8'd0);
    check("pass_br_n",    bus_if.vme_br_n,    8'd1);
    check("pass_bbsy_n",  bus_if.vme_bbsy_n,  8'd1);
    bus_if.vme_bgin_n = 1'b1;
    tick(2);
    check("pass_rel_lat", bus_if.vme_bgout_n, 8'd0);
    tick(1);
    check("pass_high",    bus_if.vme_bgout_n, 8'd1);
    tick(2);

    // Normal ownership
    bus_if.req = 1'b1;
    tick(1);
    check("own_br_n",     bus_if.vme_br_n,    8'd0);
    bus_if.vme_bgin_n = 1'b0;
    tick(2);
    check("own_bbsy_pre", bus_if.vme_bbsy_n,  8'd1);
    tick(1);
    check("own_bbsy_n",   bus_if.vme_bbsy_n,  8'd0);
    check("own_br_rel",   bus_if.vme_br_n,    8'd1);
    check("own_grant0",   bus_if.grant,       8'd0);
    bus_if.req = 1'b0;
    tick(1);
    check("own_grant",    bus_if.grant,       8'd1);
    check("own_bgout_n",  bus_if.vme_bgout_n, 8'd1);
    tick(5);
    bus_if.done = 1'b1;
    tick(1);
    bus_if.done = 1'b0;
    check("done_bbsy_n",  bus_if.vme_bbsy_n,  8'd1);
    check("done_grant",   bus_if.grant,       8'd0);
    tick(3);
    check("rel_bgout_n",  bus_if.vme_bgout_n, 8'd1);
    bus_if.vme_bgin_n = 1'b1;
    tick(5);
    check("rel_idle_br",  bus_if.vme_br_n,    8'd1);

    // Minimum BBSY hold: done right after grant still holds BBSY 4 cycles
    acquire();
    bus_if.done = 1'b1;
    tick(1);
    bus_if.done = 1'b0;
    check("hold_c3", bus_if.vme_bbsy_n, 8'd0);
    tick(1);
    check("hold_c4", bus_if.vme_bbsy_n, 8'd0);
    tick(1);
    check("hold_rel",   bus_if.vme_bbsy_n, 8'd1);
    check("hold_grant", bus_if.grant,      8'd0);
    bus_if.vme_bgin_n = 1'b1;
    tick(5);

    // BCLR asks the owner to release early
    acquire();
    tick(4);
    bus_if.vme_bclr_n = 1'b0;
    tick(2);
    check("bclr_lat",  bus_if.rel_req, 8'd0);
    tick(1);
    check("bclr_rel_req", bus_if.rel_req, 8'd1);
    bus_if.done = 1'b1;
    tick(1);
    bus_if.done = 1'b0;
    check("bclr_done_rr",   bus_if.rel_req,   8'd0);
    check("bclr_done_bbsy", bus_if.vme_bbsy_n, 8'd1);
    bus_if.vme_bclr_n = 1'b1;
    bus_if.vme_bgin_n = 1'b1;
    tick(5);

    // Grant race: a forwarded grant is not stolen
    bus_if.vme_bgin_n = 1'b0;
    tick(3);
    check("race_pass", bus_if.vme_bgout_n, 8'd0);
    bus_if.req = 1'b1;
    tick(3);
    check("race_bgout", bus_if.vme_bgout_n, 8'd0);
    check("race_br_n",  bus_if.vme_br_n,    8'd1);
    bus_if.vme_bgin_n = 1'b1;
    tick(3);
    check("race_bg_hi", bus_if.vme_bgout_n, 8'd1);
    check("race_br_wait", bus_if.vme_br_n,  8'd1);
    tick(1);
    check("race_br_req", bus_if.vme_br_n,   8'd0);

    // Dropping req in REQ withdraws the request
    bus_if.req = 1'b0;
    tick(1);
    check("drop_br_n", bus_if.vme_br_n, 8'd1);
    tick(2);

`ifdef VME_REQUESTER_TIMEOUT_EN
    bus_if.req = 1'b1;
    tick(1);
    check("to_br_n",   bus_if.vme_br_n, 8'd0);
    tick(9);
    check("to_pre_br",  bus_if.vme_br_n, 8'd0);
    check("to_pre_err", bus_if.req_err,  8'd0);
    tick(1);
    check("to_br_rel", bus_if.vme_br_n, 8'd1);
    check("to_err",    bus_if.req_err,  8'd1);
    tick(1);
    check("to_err_pulse", bus_if.req_err, 8'd0);
    tick(3);
    check("to_blocked", bus_if.vme_br_n, 8'd1);
    bus_if.req = 1'b0;
    tick(1);
    bus_if.req = 1'b1;
    tick(1);
    check("to_retry", bus_if.vme_br_n, 8'd0);
    bus_if.req = 1'b0;
    tick(2);
`else
    bus_if.req = 1'b1;
    tick(21);
    check("nto_br_n", bus_if.vme_br_n, 8'd0);
    check("nto_err",  bus_if.req_err,  8'd0);
    bus_if.req = 1'b0;
    tick(2);
`endif

    // Asynchronous reset mid-ownership
    acquire();
    check("ar_grant_pre", bus_if.grant, 8'd1);
    reset = 1'b1;
    #2;
    check("ar_bbsy_n", bus_if.vme_bbsy_n, 8'd1);
    check("ar_grant",  bus_if.grant,      8'd0);
    check("ar_br_n",   bus_if.vme_br_n,   8'd1);
    bus_if.vme_bgin_n = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vme_requester.md
Name: vme_requester

Overview:
- Per-slot VME bus requester for one local master on a single bus-request level.
- Drives one BR line and BBSY, receives the BG daisy chain from the upstream slot, and forwards BG to the downstream slot when not requesting.
- Sits directly upstream of the round-robin bus arbiter: it produces the BR/BBSY the arbiter consumes and consumes the BG/BCLR the arbiter produces.
- Presents a simple req/grant/done handshake to the local master.

Parameters:
- BBSY_MIN_CYC, 4, minimum clk cycles vme_bbsy_n is held low once asserted.
- GRANT_TO_CYC, 255, clk cycles waiting for BGIN before timeout (used only with the optional feature); 8-bit counter.

Ports:
- clk  in  1  system clock (faster than the 1 MHz arbiter clock).
- reset  in  1  asynchronous, active-high.
- req  in  1  local master requests bus ownership; level, held until grant.
- done  in  1  single-cycle pulse from local master: ownership finished.
- grant  out  1  local master owns the bus.
- rel_req  out  1  asks the local master to finish early; high while owner and vme_bclr_n is low.
- req_err  out  1  single-cycle pulse on grant timeout (optional feature only; tied 0 otherwise).
- vme_bgin_n  in  1  bus grant in from the upstream daisy chain; asynchronous.
- vme_bclr_n  in  1  bus clear from the arbiter; asynchronous.
- vme_bbsy_in_n  in  1  sensed wired-OR BBSY line; asynchronous.
- vme_br_n  out  1  bus request, open-drain style, active low.
- vme_bgout_n  out  1  bus grant out to the downstream slot.
- vme_bbsy_n  out  1  bus busy drive, active low.

Behaviour:
- Synchronisation: vme_bgin_n, vme_bclr_n and vme_bbsy_in_n each pass through a 2-flop synchronizer reset to 1. All decisions use the synchronized versions: bgin_s, bclr_s, bbsy_s.
- Reset values: vme_br_n=1, vme_bgout_n=1, vme_bbsy_n=1, grant=0, rel_req=0, req_err=0; state=IDLE.
- IDLE:
  - vme_bgout_n follows bgin_s (pass-through, 1 cycle after synchronizer).
  - If req=1 and bgin_s=1 and not passing: drive vme_br_n=0 and go to REQ.
  - If req rises while bgin_s=0 (grant already being passed): keep passing. Enter REQ only after bgin_s returns high, so a grant already forwarded downstream is never stolen.
- REQ:
  - vme_br_n=0, vme_bgout_n=1.
  - When bgin_s=0 and bbsy_s=1: drive vme_bbsy_n=0, release vme_br_n=1, load the hold counter with BBSY_MIN_CYC, and go to OWN.
  - If req drops while in REQ: release BR and return to IDLE. Any BG arriving later is passed downstream.
- OWN:
  - grant=1 from the cycle after vme_bbsy_n asserts. vme_bgout_n stays 1 even if bgin_s stays low.
  - rel_req = ~bclr_s.
  - On done=1: if the hold counter is 0, go to RELEASE; otherwise go to RELEASE when it reaches 0.
  - done and a bclr assertion in the same cycle: done wins, rel_req pulses at most 1 cycle.
- RELEASE:
  - vme_bbsy_n=1, grant=0, rel_req=0.
  - Wait until bgin_s=1, so no stale grant is reused, then go to IDLE.
  - If req is still high, a new request is made from IDLE; there is no back-to-back ownership.
- Hold counter: 3-bit, saturating down-counter; it decrements in OWN only.
- Asynchronous reset mid-ownership: BBSY and BR release immediately and grant drops in the same instant.

Optional Feature:
- Macro: VME_REQUESTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in REQ.
  - If it reaches GRANT_TO_CYC with no grant: release vme_br_n, pulse req_err for 1 cycle, and return to IDLE. The local master must drop and re-raise req to retry.
  - The counter clears on every entry to REQ.
- Undefined: the counter is absent, REQ waits indefinitely, and req_err is constant 0.

Decomposition:
- Package vme_req_pkg holds:
  - the state enum (IDLE, REQ, OWN, RELEASE), 2 bits;
  - the SYNC_STAGES=2 constant;
  - the counter width constants.
- One sub-module, vme_sync2: a 2-flop synchronizer with reset value 1, instantiated 3 times.

Test Plan:
- Idle pass-through: req=0, bgin_n driven low -> vme_bgout_n low 3 clk later, BR/BBSY stay 1; bgin_n high -> bgout_n high 3 clk later.
- Normal ownership: req=1 -> br_n=0 next cycle. Then bgin_n=0 with bbsy_in_n=1 -> bbsy_n=0 and br_n=1, grant=1 one cycle later, bgout_n stays 1. Then done pulse -> bbsy_n=1, grant=0.
- Minimum hold: done pulse 1 cycle after grant with BBSY_MIN_CYC=4 -> bbsy_n stays low 4 cycles total before release.
- BCLR: owner, bclr_n=0 -> rel_req=1 after 2-3 cycles. done -> rel_req=0, bbsy_n=1.
- Grant race: bgin_n low and passing, then req=1 -> bgout_n stays low, br_n stays 1 until bgin_n high, then br_n=0.
- Timeout (VME_REQUESTER_TIMEOUT_EN, GRANT_TO_CYC=10): req=1, bgin_n held 1 -> after 10 cycles br_n=1, req_err pulses once, state IDLE.
